awg_delay_loader: RTL

Host-side sequencer that stores a per-port delay table and streams it, one 64-bit word at a time, into the UART transmit path (`UART_TX_DATA`) toward an AWG board. On the AWG side the words are decoded into writes of the four-port delay RAM. The block owns ordering, word packing, the valid/ready handshake with the transmitter, and a fixed inter-word gap so the receiver can finish decoding each word.

---
 rtl/awg_delay_pkg.sv | 40 ++++
 rtl/delay_tbl_ram.sv | 32 +++
 rtl/awg_delay_loader.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/awg_delay_pkg.sv
// awg_delay_pkg: shared definitions for the AWG delay-table loader.
//   - Bit positions of the fields inside the 64-bit word sent to the AWG.
//   - Sequencer state encoding.
//   - pack_word(): assembles one transmit word from its fields.
package awg_delay_pkg;

   localparam int NUM_PORTS  = 4;

   localparam int AWG_ID_MSB = 63;
   localparam int AWG_ID_LSB = 59;
   localparam int PORT_MSB   = 58;
   localparam int PORT_LSB   = 57;
   localparam int ADDR_MSB   = 47;
   localparam int ADDR_LSB   = 32;
   localparam int DELAY_MSB  = 31;
   localparam int DELAY_LSB  = 0;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_SEND = 3'd2,
      ST_GAP  = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   // Bits [56:48] are reserved and always zero.
   function automatic logic [63:0] pack_word(input logic [4:0]  awg_id,
                                             input logic [1:0]  port,
                                             input logic [15:0] entry,
                                             input logic [31:0] delay);
      logic [63:0] w;
      w = 64'd0;
      w[AWG_ID_MSB:AWG_ID_LSB] = awg_id;
      w[PORT_MSB:PORT_LSB]     = port;
      w[ADDR_MSB:ADDR_LSB]     = entry;
      w[DELAY_MSB:DELAY_LSB]   = delay;
      return w;
   endfunction

endpackage

// File: rtl/delay_tbl_ram.sv
// delay_tbl_ram: simple dual-port delay table, NUM_PORTS x DEPTH x DELAY_W.
//   clk   : clock
//   wen   : write enable; waddr = {port, entry}, wdata = delay value
//   raddr : read address {port, entry}
//   rdata : registered read data, one cycle after raddr
// Contents are deliberately not reset so the array maps onto RAM primitives.
module delay_tbl_ram
   import awg_delay_pkg::*;
#(
   parameter int DEPTH   = 16,
   parameter int DELAY_W = 16,
   parameter int AW      = 4
) (
   input  logic               clk,
   input  logic               wen,
   input  logic [AW+1:0]      waddr,
   input  logic [DELAY_W-1:0] wdata,
   input  logic [AW+1:0]      raddr,
   output logic [DELAY_W-1:0] rdata
);

   logic [DELAY_W-1:0] mem [0:NUM_PORTS*DEPTH-1];

   // Write port and synchronous read port.
   always_ff @(posedge clk) begin
      if (wen) begin
         mem[waddr] <= wdata;
      end
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/awg_delay_loader.sv
// awg_delay_loader: stores a per-port delay table and streams it, port-major,
// one 64-bit word at a time into the UART transmitter with a fixed gap.
//   I_clk_10M, I_rst_n              : clock, async active-low reset
//   I_awg_id, I_entry_cnt, I_start  : run parameters, latched on start
//   I_abort                         : stops a run without a done pulse
//   I_tbl_wen/port/addr/wdata       : table write port (IDLE only)
//   O_data, O_data_valid, I_tx_ready: word handshake toward the transmitter
//   O_busy, O_done, O_word_cnt      : run status
module awg_delay_loader
   import awg_delay_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int DELAY_W    = 16,
   parameter int GAP_CYCLES = 8,
   parameter int AW         = $clog2(DEPTH)
) (
   input  logic               I_clk_10M,
   input  logic               I_rst_n,
   input  logic [4:0]         I_awg_id,
   input  logic [AW:0]        I_entry_cnt,
   input  logic               I_tbl_wen,
   input  logic [1:0]         I_tbl_port,
   input  logic [AW-1:0]      I_tbl_addr,
   input  logic [DELAY_W-1:0] I_tbl_wdata,
   input  logic               I_start,
   input  logic               I_abort,
   output logic [63:0]        O_data,
   output logic               O_data_valid,
   input  logic               I_tx_ready,
   output logic               O_busy,
   output logic               O_done,
   output logic [AW+2:0]      O_word_cnt
);

   localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   state_t             state_r;
   logic [4:0]         awg_id_r;
   logic [AW:0]        n_r;
   logic [AW-1:0]      entry_r;
   logic [1:0]         port_r;
   logic [GAP_W-1:0]   gap_cnt_r;
   logic               last_r;
   logic [DELAY_W-1:0] rd_delay;
   logic [AW:0]        n_start;
   logic [AW+2:0]      word_total;
   logic               last_entry;
   logic               tbl_wen_ok;

   assign n_start    = (I_entry_cnt > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : I_entry_cnt;
   assign word_total = {n_r, 2'b00};
   assign last_entry = ({1'b0, entry_r} == (n_r - (AW+1)'(1)));
   assign tbl_wen_ok = I_tbl_wen && (state_r == ST_IDLE);

   // The counters are parked at {0,0} in IDLE and advanced on every accepted
   // word, so the RAM is always reading the next word's entry; its data is
   // therefore ready by the time RD captures it into O_data.
   delay_tbl_ram #(
      .DEPTH   (DEPTH),
      .DELAY_W (DELAY_W),
      .AW      (AW)
   ) u_tbl (
      .clk   (I_clk_10M),
      .wen   (tbl_wen_ok),
      .waddr ({I_tbl_port, I_tbl_addr}),
      .wdata (I_tbl_wdata),
      .raddr ({port_r, entry_r}),
      .rdata (rd_delay)
   );

   // Sequencer with registered outputs.
   always_ff @(posedge I_clk_10M or negedge I_rst_n) begin
      if (!I_rst_n) begin
         state_r      <= ST_IDLE;
         awg_id_r     <= 5'd0;
         n_r          <= '0;
         entry_r      <= '0;
         port_r       <= 2'd0;
         gap_cnt_r    <= '0;
         last_r       <= 1'b0;
         O_data       <= 64'd0;
         O_data_valid <= 1'b0;
         O_busy       <= 1'b0;
         O_done       <= 1'b0;
         O_word_cnt   <= '0;
      end else begin
         O_done <= 1'b0;
         if ((state_r != ST_IDLE) && I_abort) begin
            // Abort keeps O_word_cnt so the host can see how far it got.
            state_r      <= ST_IDLE;
            O_data_valid <= 1'b0;
            O_busy       <= 1'b0;
            entry_r      <= '0;
            port_r       <= 2'd0;
            gap_cnt_r    <= '0;
         end else begin
            case (state_r)
               ST_IDLE: begin
                  if (I_start) begin
                     awg_id_r   <= I_awg_id;
                     n_r        <= n_start;
                     O_word_cnt <= '0;
                     O_busy     <= 1'b1;
                     entry_r    <= '0;
                     port_r     <= 2'd0;
                     last_r     <= 1'b0;
                     if (n_start == '0) begin
                        state_r <= ST_FIN;
                        O_done  <= 1'b1;
                     end else begin
                        state_r <= ST_RD;
                     end
                  end
               end
               ST_RD: begin
                  O_data       <= pack_word(awg_id_r, port_r, 16'(entry_r), 32'(rd_delay));
                  O_data_valid <= 1'b1;
                  state_r      <= ST_SEND;
               end
               ST_SEND: begin
                  if (I_tx_ready) begin
                     O_data_valid <= 1'b0;
                     O_word_cnt   <= O_word_cnt + (AW+3)'(1);
                     last_r       <= ((O_word_cnt + (AW+3)'(1)) == word_total);
                     gap_cnt_r    <= '0;
                     state_r      <= ST_GAP;
                     // After port 3 the port index wraps to 0, leaving the
                     // counters parked for the next run.
                     if (last_entry) begin
                        entry_r <= '0;
                        port_r  <= port_r + 2'd1;
                     end else begin
                        entry_r <= entry_r + AW'(1);
                     end
                  end
               end
               ST_GAP: begin
                  if (gap_cnt_r == GAP_W'(GAP_CYCLES - 1)) begin
                     if (last_r) begin
                        state_r <= ST_FIN;
                        O_done  <= 1'b1;
                     end else begin
                        state_r <= ST_RD;
                     end
                  end else begin
                     gap_cnt_r <= gap_cnt_r + GAP_W'(1);
                  end
               end
               ST_FIN: begin
                  state_r <= ST_IDLE;
                  O_busy  <= 1'b0;
               end
               default: begin
                  state_r      <= ST_IDLE;
                  O_data_valid <= 1'b0;
                  O_busy       <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
